btn_toggle_debounce: RTL
========================

Name: btn_toggle_debounce

Overview:
- Produces the toggle-enable for the team's asynchronous-reset T flip-flop (t_ff_async) from a raw, bouncy pushbutton.
- Synchronises the button, debounces it with a consecutive-sample counter, and emits exactly one single-cycle t_pulse per accepted press.
- t_pulse drives the T flip-flop's t input directly, so each physical press toggles q exactly once.
- Also provides a debounced button level and a release pulse for other consumers.

Parameters:
- SYNC_STAGES, 2: synchroniser depth; legal values >= 2.
- DEBOUNCE_CYCLES, 4: number of consecutive identical synchronised samples needed to accept a press or a release; legal values >= 1.
- BTN_ACTIVE_LOW, 0: when 1, btn_in is inverted before the synchroniser, so a low input means "pressed".

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- btn_in  input  1  raw asynchronous button; may bounce or glitch.
- t_pulse  output  1  one-cycle pulse per accepted press; feeds the T flip-flop t input.
- rel_pulse  output  1  one-cycle pulse per accepted release.
- btn_level  output  1  debounced level: 1 from accepted press until accepted release.

Behaviour:
- Reset (rst_n=0) acts immediately, independent of clk:
  - all synchroniser stages load the "released" value (0 after optional inversion);
  - FSM goes to IDLE and the counter to 0;
  - t_pulse=0, rel_pulse=0, btn_level=0.
- Synchroniser:
  - p_raw = btn_in XOR BTN_ACTIVE_LOW;
  - p_raw passes through a SYNC_STAGES flop chain; the last stage is press_s.
  - No combinational path from btn_in to any output.
- Counter: width clog2(DEBOUNCE_CYCLES+1); it never exceeds DEBOUNCE_CYCLES.
- FSM states: IDLE, WAIT_PRESS, PRESSED, WAIT_REL.
- IDLE:
  - press_s=1: cnt<=1; if DEBOUNCE_CYCLES==1, go directly to PRESSED with t_pulse<=1; otherwise go to WAIT_PRESS.
  - press_s=0: stay, cnt<=0.
- WAIT_PRESS:
  - press_s=0 (bounce): return to IDLE, cnt<=0, no pulse.
  - press_s=1 and cnt+1==DEBOUNCE_CYCLES: go to PRESSED, t_pulse<=1, cnt<=0.
  - press_s=1 otherwise: cnt<=cnt+1.
- PRESSED: mirrors IDLE with press_s=0 as the trigger. Goes to WAIT_REL, or directly to IDLE with rel_pulse<=1 when DEBOUNCE_CYCLES==1.
- WAIT_REL: mirrors WAIT_PRESS.
  - press_s=1 returns to PRESSED, no pulse.
  - Completion goes to IDLE with rel_pulse<=1.
- Pulse and level outputs:
  - t_pulse and rel_pulse are registered and high for exactly one cycle; they are never high together.
  - btn_level is registered: 1 in PRESSED and WAIT_REL, 0 otherwise, so it rises in the same cycle as t_pulse.
- Latency: btn_in rises (and stays) between edge 0 and edge 1 → t_pulse is high between edges SYNC_STAGES+DEBOUNCE_CYCLES and SYNC_STAGES+DEBOUNCE_CYCLES+1. Release latency is the same.
- Boundary conditions:
  - Bounce shorter than DEBOUNCE_CYCLES samples: restarts the count, no pulse.
  - Button held indefinitely: exactly one t_pulse and no repeat.
  - Reset asserted mid-count or during a pulse: the pulse drops immediately and the partial count is discarded.
  - Button held across reset release: treated as a fresh press; t_pulse fires SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge with rst_n=1.
  - Pulses can be no closer than 2*DEBOUNCE_CYCLES cycles apart.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock; T-FF instanced downstream):
- Clean press: rst_n released, btn_in 0→1 between edges 0 and 1, held 20 cycles → t_pulse=1 only between edges 6 and 7; btn_level=1 from edge 6; T-FF q 0→1 once.
- Bounce: btn_in toggles 1,0,1,0 on successive cycles, then stays 1 → no t_pulse during the bounce; one t_pulse 6 edges after the final rise.
- Release: after an accepted press, btn_in→0 → rel_pulse one cycle 6 edges later; btn_level→0 in the same cycle; t_pulse stays 0; q unchanged.
- Short glitch: btn_in high for 3 cycles, then low → no t_pulse, btn_level stays 0.
- Mid-operation reset: rst_n=0 asynchronously 3 cycles after btn_in rises (mid-count), held 10 ns, button still held → outputs 0 immediately; t_pulse 6 edges after reset release.
- Polarity and minimum debounce: BTN_ACTIVE_LOW=1, DEBOUNCE_CYCLES=1, btn_in 1→0 → t_pulse 3 edges later; with btn_in held, no further pulses.

Source files
------------

// File: rtl/btn_toggle_debounce.sv
// btn_toggle_debounce: synchronised, debounced pushbutton giving press/release pulses and a clean level
module btn_toggle_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic t_pulse,
  output logic rel_pulse,
  output logic btn_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_REL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic t_pulse_q, t_pulse_d;
  logic rel_pulse_q, rel_pulse_d;
  logic btn_level_q, btn_level_d;
  logic press_s;
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in ^ BTN_ACTIVE_LOW};
  assign press_s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_pulse_q   <= 1'b0;
      rel_pulse_q <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_pulse_q   <= t_pulse_d;
      rel_pulse_q <= rel_pulse_d;
      btn_level_q <= btn_level_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d   = press_s ? CNT_ONE : '0;
        state_d = !press_s ? IDLE : DIRECT ? PRESSED : WAIT_PRESS;
      end
      WAIT_PRESS: begin
        cnt_d   = (press_s && cnt_q != CNT_LAST) ? cnt_q + CNT_ONE : '0;
        state_d = !press_s ? IDLE : (cnt_q == CNT_LAST) ? PRESSED : WAIT_PRESS;
      end
      PRESSED: begin
        cnt_d   = !press_s ? CNT_ONE : '0;
        state_d = press_s ? PRESSED : DIRECT ? IDLE : WAIT_REL;
      end
      WAIT_REL: begin
        cnt_d   = (!press_s && cnt_q != CNT_LAST) ? cnt_q + CNT_ONE : '0;
        state_d = press_s ? PRESSED : (cnt_q == CNT_LAST) ? IDLE : WAIT_REL;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_comb begin
    t_pulse_d   = (state_d == PRESSED) && (state_q == IDLE || state_q == WAIT_PRESS);
    rel_pulse_d = (state_d == IDLE) && (state_q == PRESSED || state_q == WAIT_REL);
    btn_level_d = (state_d == PRESSED) || (state_d == WAIT_REL);
  end
  assign t_pulse   = t_pulse_q;
  assign rel_pulse = rel_pulse_q;
  assign btn_level = btn_level_q;
endmodule
